fifo_rx: RTL and testbench

//   Receive-side byte buffer. Sits directly downstream of the UART receiver and

---
 rtl/fifo_rx.sv | 145 ++++++++++++++
 tb/tb_fifo_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rx.sv
// fifo_rx: receive-side frame buffer between the UART receiver and the host/DMA.
// Each entry is {frame_err, data byte}, captured on the end-of-frame strobe.
// Pops are registered: the popped entry shows up on data_out/err_out after the
// edge and data_valid marks that cycle. All status flags are registered and are
// derived from the same next-count value, so they always agree with count.
module fifo_rx #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk_fifo_rx,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              frame_err,
  input  logic              rx_end,
  input  logic              rd_en,
  input  logic              clr_overrun,
  output logic [DATA_W-1:0] data_out,
  output logic              err_out,
  output logic              data_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overrun
);

  localparam int               DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]  CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  CNT_AF   = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W:0]     mem [DEPTH];

  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic                af_q, af_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                err_out_q, err_out_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  logic                do_pop;
  logic                do_push;
  logic                drop;
  logic [DATA_W:0]     rd_entry;

  // Handshake decode: a pop frees a slot in the same cycle, so a full FIFO
  // still accepts a frame when it is also being popped. A pop on an empty
  // FIFO is ignored, which makes push+pop on empty a plain push.
  always_comb begin
    do_pop   = rd_en && !empty_q;
    do_push  = rx_end && (!full_q || do_pop);
    drop     = rx_end && full_q && !do_pop;
    rd_entry = mem[rd_ptr_q];
  end

  // Next-state for pointers, occupancy, flags, output register and overrun.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    err_out_d  = err_out_q;
    valid_d    = 1'b0;
    overrun_d  = overrun_q;

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (do_pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = rd_entry[DATA_W-1:0];
      err_out_d  = rd_entry[DATA_W];
      valid_d    = 1'b1;
    end

    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_ONE;
    end

    // A drop in the same cycle as a clear must not be lost.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
    af_d    = (count_d >= CNT_AF);
  end

  // Control and status registers, cleared asynchronously.
  always_ff @(posedge clk_fifo_rx or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      data_out_q <= '0;
      err_out_q  <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      af_q       <= af_d;
      data_out_q <= data_out_d;
      err_out_q  <= err_out_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Storage array write; not reset. On push+pop at full the read above sees
  // the old entry because the write lands at the edge.
  always_ff @(posedge clk_fifo_rx) begin
    if (do_push) begin
      mem[wr_ptr_q] <= {frame_err, data_in};
    end
  end

  assign data_out    = data_out_q;
  assign err_out     = err_out_q;
  assign data_valid  = valid_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign count       = count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_fifo_rx.sv
// Directed bench for fifo_rx: ordering, fill/overrun, simultaneous push+pop,
// error-bit storage, pointer wrap and asynchronous reset.
module tb_fifo_rx;

  logic       clk_fifo_rx = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       frame_err;
  logic       rx_end;
  logic       rd_en;
  logic       clr_overrun;
  logic [7:0] data_out;
  logic       err_out;
  logic       data_valid;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q_model [$];

  fifo_rx #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(12)) dut (
    .clk_fifo_rx (clk_fifo_rx),
    .rst         (rst),
    .data_in     (data_in),
    .frame_err   (frame_err),
    .rx_end      (rx_end),
    .rd_en       (rd_en),
    .clr_overrun (clr_overrun),
    .data_out    (data_out),
    .err_out     (err_out),
    .data_valid  (data_valid),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overrun     (overrun)
  );

  always #5 clk_fifo_rx = ~clk_fifo_rx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_fifo_rx);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic e);
    data_in   = b;
    frame_err = e;
    rx_end    = 1'b1;
    tick();
    rx_end    = 1'b0;
    frame_err = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp_d, input logic exp_e);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(data_valid), 32'd1);
    chk({tag, "_data"}, 32'(data_out), 32'(exp_d));
    chk({tag, "_err"}, 32'(err_out), 32'(exp_e));
  endtask

  initial begin
    rst         = 1'b1;
    data_in     = '0;
    frame_err   = 1'b0;
    rx_end      = 1'b0;
    rd_en       = 1'b0;
    clr_overrun = 1'b0;
    #12;
    chk("rst0_empty", 32'(empty), 32'd1);
    chk("rst0_count", 32'(count), 32'd0);
    chk("rst0_full", 32'(full), 32'd0);
    chk("rst0_dout", 32'(data_out), 32'd0);
    rst = 1'b0;
    tick();

    // Order
    push(8'h55, 1'b0);
    push(8'hA3, 1'b0);
    push(8'h0F, 1'b0);
    chk("ord_count3", 32'(count), 32'd3);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("ord_pop0_valid", 32'(data_valid), 32'd1);
    chk("ord_pop0_data", 32'(data_out), 32'h55);
    tick();
    chk("ord_idle_valid", 32'(data_valid), 32'd0);
    chk("ord_hold_data", 32'(data_out), 32'h55);
    pop_chk("ord_pop1", 8'hA3, 1'b0);
    pop_chk("ord_pop2", 8'h0F, 1'b0);
    chk("ord_count0", 32'(count), 32'd0);
    chk("ord_empty", 32'(empty), 32'd1);
    // pop while empty: ignored
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("emp_pop_valid", 32'(data_valid), 32'd0);
    chk("emp_pop_data", 32'(data_out), 32'h0F);
    chk("emp_pop_count", 32'(count), 32'd0);

    // Reset mid-sequence (asynchronous)
    push(8'h11, 1'b1);
    push(8'h22, 1'b0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    chk("arst_dout", 32'(data_out), 32'd0);
    chk("arst_valid", 32'(data_valid), 32'd0);
    tick();
    #2;
    rst = 1'b0;
    tick();

    // Fill, almost_full, full, overrun
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1'b0);
      if (i == 10) chk("fill_af_11", 32'(almost_full), 32'd0);
      if (i == 11) chk("fill_af_12", 32'(almost_full), 32'd1);
      if (i == 14) chk("fill_full_15", 32'(full), 32'd0);
    end
    chk("fill_full_16", 32'(full), 32'd1);
    chk("fill_count_16", 32'(count), 32'd16);
    chk("fill_ovr_pre", 32'(overrun), 32'd0);
    push(8'hEE, 1'b0);
    chk("fill_ovr", 32'(overrun), 32'd1);
    chk("fill_count_drop", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      pop_chk($sformatf("fill_pop%0d", i), 8'(i), 1'b0);
    end
    chk("fill_empty", 32'(empty), 32'd1);
    chk("fill_af_end", 32'(almost_full), 32'd0);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("fill_ovr_clr", 32'(overrun), 32'd0);

    // Simultaneous push+pop at full and at empty
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0);
    data_in = 8'h77;
    rx_end  = 1'b1;
    rd_en   = 1'b1;
    tick();
    rx_end  = 1'b0;
    rd_en   = 1'b0;
    chk("sim_full_count", 32'(count), 32'd16);
    chk("sim_full_data", 32'(data_out), 32'h10);
    chk("sim_full_valid", 32'(data_valid), 32'd1);
    chk("sim_full_ovr", 32'(overrun), 32'd0);
    for (int i = 1; i < 16; i++) begin
      pop_chk($sformatf("sim_pop%0d", i), 8'(8'h10 + i), 1'b0);
    end
    pop_chk("sim_pop77", 8'h77, 1'b0);
    chk("sim_empty", 32'(empty), 32'd1);
    data_in = 8'h42;
    rx_end  = 1'b1;
    rd_en   = 1'b1;
    tick();
    rx_end  = 1'b0;
    rd_en   = 1'b0;
    chk("sim_emp_count", 32'(count), 32'd1);
    chk("sim_emp_valid", 32'(data_valid), 32'd0);
    chk("sim_emp_data", 32'(data_out), 32'h77);
    pop_chk("sim_pop42", 8'h42, 1'b0);

    // Error bit storage, set-wins overrun
    push(8'h81, 1'b1);
    push(8'h82, 1'b0);
    pop_chk("err_pop81", 8'h81, 1'b1);
    pop_chk("err_pop82", 8'h82, 1'b0);
    for (int i = 0; i < 16; i++) push(8'(8'hC0 + i), 1'b0);
    data_in     = 8'h99;
    rx_end      = 1'b1;
    clr_overrun = 1'b1;
    tick();
    rx_end      = 1'b0;
    clr_overrun = 1'b0;
    chk("err_setwins", 32'(overrun), 32'd1);
    chk("err_count", 32'(count), 32'd16);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("err_clr", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) pop_chk($sformatf("err_pop%0d", i), 8'(8'hC0 + i), 1'b0);

    // Wrap: interleaved push/pop with count held at or below 3
    for (int i = 0; i < 2; i++) begin
      q_model.push_back(8'(i * 37 + 5));
      push(8'(i * 37 + 5), 1'b0);
    end
    for (int i = 2; i < 42; i++) begin
      logic [7:0] exp_b;
      q_model.push_back(8'(i * 37 + 5));
      push(8'(i * 37 + 5), 1'b0);
      if (count > 5'd3) chk($sformatf("wrap_cnt%0d", i), 32'(count), 32'd3);
      exp_b = q_model.pop_front();
      pop_chk($sformatf("wrap_pop%0d", i), exp_b, 1'b0);
    end
    while (q_model.size() > 0) begin
      logic [7:0] exp_b;
      exp_b = q_model.pop_front();
      pop_chk("wrap_drain", exp_b, 1'b0);
    end
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_ovr", 32'(overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
